// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared definitions for the push-button / sensor debouncer.
//   - state_e          : 3-bit Moore state encoding of the debounce FSM
//   - MinStableCycles  : smallest legal STABLE_CYCLES
//   - MinSyncStages    : smallest legal SYNC_STAGES
//   - cnt_width()      : width of the stable-time counter for a given STABLE_CYCLES
package debounce_pkg;

  typedef enum logic [2:0] {
    StLow      = 3'd0,
    StRiseWait = 3'd1,
    StPulse    = 3'd2,
    StHigh     = 3'd3,
    StFallWait = 3'd4
  } state_e;

  localparam int unsigned MinStableCycles = 2;
  localparam int unsigned MinSyncStages   = 2;

  // ceil(log2(stable_cycles)); clamped to 1 so an illegal value still elaborates far
  // enough for the parameter check to report it.
  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    if (stable_cycles < 2) begin
      return 1;
    end
    return $clog2(stable_cycles);
  endfunction

endpackage

// File: rtl/input_sync.sv
// input_sync
//   Parameterised flop chain that brings an asynchronous level into the clk domain.
//   Reusable for any slow asynchronous input.
//   Parameters:
//     STAGES : number of flops in the chain (>= 2)
//   Ports:
//     clk : clock, rising edge
//     rst : asynchronous active-low reset, clears every stage to 0
//     d   : raw asynchronous input
//     q   : synchronised output (last stage)
module input_sync
  import debounce_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (STAGES < MinSyncStages) begin : gen_bad_stages
    $error("input_sync: STAGES must be at least %0d", MinSyncStages);
  end

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_pulse.sv
// debounce_pulse
//   Conditions a raw, bouncing asynchronous input: synchronises it, accepts a level
//   change only after STABLE_CYCLES identical samples, and emits one single-cycle
//   pulse per accepted rising edge. Falling edges update the level but never pulse.
//   Parameters:
//     STABLE_CYCLES : identical samples needed to accept a change (>= 2)
//     SYNC_STAGES   : synchroniser depth (>= 2)
//   Ports:
//     clk    : clock, rising edge
//     rst    : asynchronous active-low reset
//     btn_in : raw asynchronous input
//     pulse  : one cycle high per accepted rising edge
//     level  : debounced level of btn_in
module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse,
  output logic level
);

  if (STABLE_CYCLES < MinStableCycles) begin : gen_bad_stable
    $error("debounce_pulse: STABLE_CYCLES must be at least %0d", MinStableCycles);
  end
  if (SYNC_STAGES < MinSyncStages) begin : gen_bad_sync
    $error("debounce_pulse: SYNC_STAGES must be at least %0d", MinSyncStages);
  end

  localparam int unsigned    CntW   = cnt_width(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic            sync;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  input_sync #(
    .STAGES(SYNC_STAGES)
  ) u_input_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_in),
    .q  (sync)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StLow;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt counts the samples already seen at the new level, so entering a wait state
  // loads 1 (the sample that triggered the transition).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StLow: begin
        if (sync) begin
          state_d = StRiseWait;
          cnt_d   = CntOne;
        end
      end
      StRiseWait: begin
        if (!sync) begin
          state_d = StLow;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StPulse;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      // Fixed one-cycle stay: a glitch seen here is judged from StHigh instead.
      StPulse: begin
        state_d = StHigh;
      end
      StHigh: begin
        if (!sync) begin
          state_d = StFallWait;
          cnt_d   = CntOne;
        end
      end
      StFallWait: begin
        if (sync) begin
          state_d = StHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StLow;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StLow;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore decode from the registered state only, so reset clears outputs at once.
  always_comb begin
    pulse = 1'b0;
    level = 1'b0;
    unique case (state_q)
      StPulse: begin
        pulse = 1'b1;
        level = 1'b1;
      end
      StHigh, StFallWait: begin
        level = 1'b1;
      end
      default: begin
        pulse = 1'b0;
        level = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_debounce_pulse.sv
module tb_debounce_pulse;

  localparam int Window = 24;

  logic clk;
  logic rst;
  logic btn_in;
  logic pulse_a, level_a;  // default parameters
  logic pulse_b, level_b;  // STABLE_CYCLES=2, SYNC_STAGES=2

  int vectors = 0;
  int errors  = 0;

  logic [1:0] sb_q[$];

  // Each record: btn high over [a0,b0) and [a1,b1) (edges counted from the first
  // edge after reset release); expected pulse at edges p0/p1; level high over
  // [l0a,l0b) and [l1a,l1b). dut 0 = default DUT, 1 = minimal DUT.
  typedef struct {
    string name;
    int    dut;
    int    a0, b0, a1, b1;
    int    p0, p1;
    int    l0a, l0b, l1a, l1b;
  } vec_t;

  vec_t vecs[12];

  debounce_pulse u_dut_a (
    .clk   (clk),
    .rst   (rst),
    .btn_in(btn_in),
    .pulse (pulse_a),
    .level (level_a)
  );

  debounce_pulse #(
    .STABLE_CYCLES(2),
    .SYNC_STAGES  (2)
  ) u_dut_b (
    .clk   (clk),
    .rst   (rst),
    .btn_in(btn_in),
    .pulse (pulse_b),
    .level (level_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic in_iv(input int e, input int lo, input int hi);
    return (e >= lo) && (e < hi);
  endfunction

  task automatic check(input string nm, input int idx, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0b expected %0b", nm, idx, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int idx, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  // Leaves rst released, returning at a falling clock edge.
  task automatic do_reset(input logic btn_level);
    @(negedge clk);
    btn_in = btn_level;
    rst    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Starts at a falling edge; edge 0 is the next rising edge.
  task automatic run_vec(input vec_t v);
    for (int e = 0; e < Window; e++) begin
      logic [1:0] exp;
      logic       act_p, act_l;
      btn_in = in_iv(e, v.a0, v.b0) || in_iv(e, v.a1, v.b1);
      sb_q.push_back({(e == v.p0) || (e == v.p1),
                      in_iv(e, v.l0a, v.l0b) || in_iv(e, v.l1a, v.l1b)});
      @(posedge clk);
      #1;
      exp   = sb_q.pop_front();
      act_p = (v.dut == 0) ? pulse_a : pulse_b;
      act_l = (v.dut == 0) ? level_a : level_b;
      check({v.name, ".pulse"}, e, act_p, exp[1]);
      check({v.name, ".level"}, e, act_l, exp[0]);
      @(negedge clk);
    end
  endtask

  initial begin
    int   npulse;
    int   nhigh;
    logic prev;
    vec_t v_rst;

    vecs[0]  = '{"clean_rise",       0, 10, 99,  0,  0, 15, -1, 15, 99,  0,  0};
    vecs[1]  = '{"rise_glitch3",     0,  4,  7,  0,  0, -1, -1,  0,  0,  0,  0};
    vecs[2]  = '{"rise_glitch1",     0,  4,  5,  0,  0, -1, -1,  0,  0,  0,  0};
    vecs[3]  = '{"rise_exact4",      0,  3,  7,  0,  0,  8, -1,  8, 13,  0,  0};
    vecs[4]  = '{"press_release",    0,  2,  9,  0,  0,  7, -1,  7, 14,  0,  0};
    vecs[5]  = '{"release_bounce2",  0,  2, 10, 12, 99,  7, -1,  7, 99,  0,  0};
    vecs[6]  = '{"fall_bounce3",     0,  1,  8, 11, 99,  6, -1,  6, 99,  0,  0};
    vecs[7]  = '{"fall_full4",       0,  1,  8, 12, 99,  6, 17,  6, 13, 17, 99};
    vecs[8]  = '{"min_clean_rise",   1, 10, 99,  0,  0, 13, -1, 13, 99,  0,  0};
    vecs[9]  = '{"min_glitch1",      1,  4,  5,  0,  0, -1, -1,  0,  0,  0,  0};
    vecs[10] = '{"min_hold2",        1,  2,  4,  0,  0,  5, -1,  5,  8,  0,  0};
    vecs[11] = '{"min_press_release",1,  2,  9,  0,  0,  5, -1,  5, 12,  0,  0};
    v_rst    = '{"reset_mid_rise",   0,  0, 99,  0,  0,  5, -1,  5, 99,  0,  0};

    // Reset is asynchronous: outputs must be 0 before any clock edge.
    rst    = 1'b0;
    btn_in = 1'b0;
    #1;
    check("reset.pulse_a", 0, pulse_a, 1'b0);
    check("reset.level_a", 0, level_a, 1'b0);
    check("reset.pulse_b", 0, pulse_b, 1'b0);
    check("reset.level_b", 0, level_b, 1'b0);

    for (int i = 0; i < 12; i++) begin
      do_reset(1'b0);
      run_vec(vecs[i]);
    end

    // Async reset from the debounced-high state clears outputs without a clock edge.
    do_reset(1'b0);
    btn_in = 1'b1;
    repeat (8) @(negedge clk);
    check("hold_high.level_a", 0, level_a, 1'b1);
    check("hold_high.level_b", 0, level_b, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    check("async_reset.level_a", 0, level_a, 1'b0);
    check("async_reset.pulse_a", 0, pulse_a, 1'b0);
    check("async_reset.level_b", 0, level_b, 1'b0);

    // Reset during RISE_WAIT with the input held high: full latency after release.
    do_reset(1'b0);
    btn_in = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("reset_rw.pulse_a", 0, pulse_a, 1'b0);
    check("reset_rw.level_a", 0, level_a, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_vec(v_rst);

    // Four clean presses, 20 cycles apart: each yields exactly one one-cycle pulse.
    do_reset(1'b0);
    npulse = 0;
    nhigh  = 0;
    prev   = 1'b0;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 20; c++) begin
        btn_in = (c < 10);
        @(posedge clk);
        #1;
        if (pulse_a) nhigh++;
        if (pulse_a && !prev) npulse++;
        prev = pulse_a;
        @(negedge clk);
      end
      check_int("press_count", p, npulse, p + 1);
      check_int("press_width", p, nhigh, p + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
